// File: rtl/reg_dump_reader_pkg.sv
// reg_dump_reader_pkg: shared core widths and dump FSM state encoding.
package reg_dump_reader_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} dump_state_e;
endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams a register-file index range out over a valid/ready port.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  input  logic [ADDR_W-1:0] startReg,
  input  logic [ADDR_W-1:0] endReg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rdReg,
  input  logic [DATA_W-1:0] rdData,
  output logic [DATA_W-1:0] outData,
  output logic [ADDR_W-1:0] outIndex,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
  output logic              done
);
  dump_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q, end_q, out_index_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, busy_q, done_q;
  assign rdReg    = ptr_q;
  assign outData  = out_data_q;
  assign outIndex = out_index_q;
  assign outValid = out_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  // Outputs are registered alongside the state so they decode the state being entered.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      end_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          ptr_q   <= startReg;
          end_q   <= endReg;
          busy_q  <= 1'b1;
          state_q <= ST_LOAD;
        end
        ST_LOAD: if (abort) begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end else begin
          out_data_q  <= rdData;
          out_index_q <= ptr_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: if (abort || (outReady && ptr_q == end_q)) begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= ST_DONE;
        end else if (outReady) begin
          out_valid_q <= 1'b0;
          ptr_q       <= ptr_q + 1'b1;
          state_q     <= ST_LOAD;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed tests with an index-queue scoreboard for reg_dump_reader.
module tb_reg_dump_reader;
  logic        clk = 1'b0, rst_ = 1'b0, start = 1'b0, abort = 1'b0, outReady = 1'b0;
  logic [4:0]  startReg = '0, endReg = '0, rdReg, outIndex;
  logic [31:0] rdData, outData;
  logic        outValid, busy, done;
  logic [31:0] mem [32];
  int          checks = 0, failures = 0, hs_cnt = 0;
  int          exp_q[$];

  always #5 clk = ~clk;
  assign rdData = mem[rdReg];

  reg_dump_reader dut (
    .clk(clk), .rst_(rst_), .start(start), .startReg(startReg), .endReg(endReg),
    .abort(abort), .rdReg(rdReg), .rdData(rdData), .outData(outData),
    .outIndex(outIndex), .outValid(outValid), .outReady(outReady),
    .busy(busy), .done(done)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", n, a, e, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int s, input int e);
    int i = s;
    while (1) begin
      exp_q.push_back(i);
      if (i == e) break;
      i = (i + 1) % 32;
    end
    startReg = 5'(s);
    endReg   = 5'(e);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  // Scoreboard: every accepted word must be the next index of the requested range.
  logic        pv = 0, ph = 0, pd = 0;
  logic [31:0] sd = 0;
  logic [4:0]  si = 0;
  always @(negedge clk) begin
    logic hs;
    int   idx;
    if (!rst_) begin
      pv = 0; ph = 0; pd = 0;
    end else begin
      if (outValid) chk("valid_implies_busy", busy, 1);
      if (outValid && pv && !ph) begin
        chk("stable_data", outData, sd);
        chk("stable_index", outIndex, si);
      end
      hs = outValid && outReady && !abort;
      if (hs) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("extra_handshake", 1, 0);
        else begin
          idx = exp_q.pop_front();
          chk("hs_index", outIndex, idx);
          chk("hs_data", outData, idx == 0 ? 0 : 32'h100 + idx);
        end
      end
      if (done) chk("done_width", pd, 0);
      pv = outValid; ph = hs; sd = outData; si = outIndex; pd = done;
    end
  end

  initial begin
    int n, h;
    mem[0] = 32'h0;
    for (int i = 1; i < 32; i++) mem[i] = 32'h100 + i;
    tick(); tick();
    chk("rst_valid", outValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", outData, 0);
    chk("rst_index", outIndex, 0);
    chk("rst_rdreg", rdReg, 0);
    rst_ = 1'b1;
    tick();
    // full range 0..31
    outReady = 1'b1;
    h = hs_cnt;
    go(0, 31);
    wait_done(n);
    chk("full_cycles", n, 64);
    chk("full_words", hs_cnt - h, 32);
    chk("full_queue_empty", exp_q.size(), 0);
    tick();
    chk("full_done_off", done, 0);
    chk("full_busy_off", busy, 0);
    // wrap-around 30..1 plus latency
    h = hs_cnt;
    go(30, 1);
    chk("lat_busy", busy, 1);
    chk("lat_valid_early", outValid, 0);
    tick();
    chk("lat_valid", outValid, 1);
    chk("lat_index", outIndex, 30);
    chk("lat_data", outData, 32'h11E);
    wait_done(n);
    chk("wrap_cycles", n, 7);
    chk("wrap_words", hs_cnt - h, 4);
    tick();
    // single word with back-pressure
    outReady = 1'b0;
    h = hs_cnt;
    go(7, 7);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", outValid, 1);
      chk("bp_data", outData, 32'h107);
      tick();
    end
    outReady = 1'b1;
    wait_done(n);
    chk("bp_cycles", n, 1);
    chk("bp_words", hs_cnt - h, 1);
    tick();
    // abort in IDLE is ignored
    abort = 1'b1;
    tick(); tick();
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);
    abort = 1'b0;
    // abort during SEND of third word
    h = hs_cnt;
    go(0, 31);
    repeat (5) tick();
    chk("abort_sending", outValid, 1);
    chk("abort_index", outIndex, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid_drop", outValid, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 1);
    tick();
    chk("abort_done_off", done, 0);
    chk("abort_busy_off", busy, 0);
    chk("abort_words", hs_cnt - h, 2);
    chk("abort_left", exp_q.size(), 30);
    exp_q.delete();
    tick();
    // second start ignored, then reset mid-dump
    h = hs_cnt;
    go(0, 31);
    tick();
    startReg = 5'd5; endReg = 5'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_ignored", outIndex, 1);
    tick();
    chk("pre_reset_words", hs_cnt - h, 2);
    rst_ = 1'b0;
    #1;
    chk("async_valid", outValid, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_data", outData, 0);
    chk("async_index", outIndex, 0);
    chk("async_rdreg", rdReg, 0);
    exp_q.delete();
    tick();
    rst_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_done", done, 0);
      chk("post_reset_busy", busy, 0);
    end
    h = hs_cnt;
    go(3, 4);
    wait_done(n);
    chk("post_reset_cycles", n, 4);
    chk("post_reset_words", hs_cnt - h, 2);
    tick(); tick();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter DATA_W, default 32, width of a register word.
REQ-002 Parameter ADDR_W, default 5, register index width; the register space has 2**ADDR_W entries.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 startReg  input  ADDR_W  first register index; sampled with start.
REQ-007 endReg  input  ADDR_W  last register index, inclusive; sampled with start.
REQ-008 abort  input  1  terminates a dump in progress.
REQ-009 rdReg  output  ADDR_W  register-file read address.
REQ-010 rdData  input  DATA_W  register-file read data, combinational from rdReg.
REQ-011 outData  output  DATA_W  captured register word.
REQ-012 outIndex  output  ADDR_W  index of the word on outData.
REQ-013 outValid  output  1  outData/outIndex valid.
REQ-014 outReady  input  1  consumer accepts the word.
REQ-015 busy  output  1  high in every non-IDLE state.
REQ-016 done  output  1  one-cycle pulse at completion or abort.

Function
REQ-017 States: IDLE, LOAD, SEND, DONE; the state register SHALL be the only control state besides the pointer and the sampled endReg.
REQ-018 IDLE: on start=1, ptr<=startReg, end<=endReg, next state LOAD; start is ignored in all other states.
REQ-019 LOAD: rdReg=ptr; outData<=rdData, outIndex<=ptr; next state SEND.
REQ-020 rdReg SHALL equal ptr in every state; it need not be meaningful outside LOAD.
REQ-021 SEND: outValid=1; outData and outIndex SHALL hold stable until outValid&&outReady.
REQ-022 SEND handshake with ptr==end: next state DONE; otherwise ptr<=ptr+1 modulo 2**ADDR_W, next state LOAD.
REQ-023 Wrap-around: endReg<startReg SHALL dump startReg..2**ADDR_W-1, then 0..endReg.
REQ-024 startReg==endReg SHALL dump exactly one word.
REQ-025 Index 0 SHALL be dumped as read; no special-casing.
REQ-026 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-027 abort in LOAD or SEND SHALL take priority over the handshake: no further word is accepted, outValid drops the next cycle, next state DONE.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 Throughput: one word per two cycles when outReady is held high.
REQ-030 Latency: start at cycle N gives busy=1 at N+1 and outValid=1 at N+2.
REQ-031 outValid SHALL be a registered decode of state==SEND, with no combinational path from outReady.

Reset
REQ-032 While rst_=0, asynchronously: state=IDLE, ptr=0, end=0, outData=0, outIndex=0, outValid=0, busy=0, done=0.
REQ-033 Reset asserted mid-dump SHALL abandon it with no done pulse; after release the block SHALL be in IDLE and wait for start.

Structure
REQ-034 The state encoding and DATA_W/ADDR_W defaults SHALL live in the shared core package used by the register file.
REQ-035 The block SHALL be a single module with no sub-modules; it connects to one read port of register_file.

Verification
REQ-036 Preload x1..x31 = 0x100+i, start with startReg=0, endReg=31, outReady=1 -> 32 words, indices 0..31, x0 word 0, done one cycle after the last handshake.
REQ-037 startReg=30, endReg=1 -> indices 30, 31, 0, 1 in that order, then done.
REQ-038 startReg=endReg=7 with outReady low for 5 cycles -> outValid held, outData=0x107 stable, single word, then done.
REQ-039 abort in SEND of the 3rd word of a 0..31 dump -> no further handshake, outValid=0 next cycle, done pulse, busy=0 after.
REQ-040 start pulsed while busy, then rst_ pulsed mid-dump -> second start ignored; after reset all outputs 0, no done pulse, and a new start dumps normally.
